// File: rtl/dcim_macro_top_if.sv
// dcim_macro_top_if
// Host <-> DCIM macro bus. Carries the compute request, the mode pins, the
// weight-row write port and the activation vector towards the macro, and
// the dot-product result and done flag back to the host.
//   start   : compute request, sampled on the rising clock edge
//   cima    : 0 unsigned, 1 signed two's complement (inputs and weights)
//   inwidth : input precision, 0 = 8-bit, 1 = 4-bit
//   wwidth  : weight precision, 0 = 8-bit, 1 = 4-bit
//   WA      : per-row write enables (multi-hot allowed)
//   D       : row write data, bit c goes to column c
//   xin0    : packed activations, lane k = xin0[8k+7:8k]
//   nout    : dot-product result
//   st      : done flag
interface dcim_macro_top_if #(
    parameter int ROWS = 8,
    parameter int COLS = 24,
    parameter int OUTW = 51
);
    logic                start;
    logic                cima;
    logic                inwidth;
    logic                wwidth;
    logic [ROWS-1:0]     WA;
    logic [COLS-1:0]     D;
    logic [8*COLS-1:0]   xin0;
    logic [OUTW-1:0]     nout;
    logic                st;

    // Host side drives requests and weights, observes the result
    modport master (
        output start, cima, inwidth, wwidth, WA, D, xin0,
        input  nout, st
    );

    // Macro side consumes requests and weights, produces the result
    modport slave (
        input  start, cima, inwidth, wwidth, WA, D, xin0,
        output nout, st
    );
endinterface

// File: rtl/dcim_macro_top.sv
// dcim_macro_top
// Digital compute-in-memory macro. An 8-row x 24-column bit-cell array
// holds 24 bit-sliced weights (row r = weight bit r). On start the macro
// computes the dot product of the 24 latched activations with the stored
// weights, one input bit-plane per clock, LSB first, and presents the
// result on nout with st raised.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : dcim_macro_top_if slave (start, modes, WA/D, xin0, nout, st)
module dcim_macro_top #(
    parameter int ROWS = 8,
    parameter int COLS = 24,
    parameter int OUTW = 51
) (
    input  logic            clk,
    input  logic            rstn,
    dcim_macro_top_if.slave bus
);

    localparam int PCW = $clog2(COLS + 1);
    // Wide enough for the signed per-plane partial sum (|partial| <= 24*255)
    localparam int PW  = 16;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ROWS-1:0][COLS-1:0] weights;

    logic [8*COLS-1:0] x_lat;
    logic              cima_lat;
    logic              inw_lat;
    logic              ww_lat;
    logic [2:0]        bit_idx;
    logic [OUTW-1:0]   acc;
    logic [OUTW-1:0]   acc_next;
    logic [OUTW-1:0]   nout_r;
    logic              st_r;

    logic              do_load;
    logic              do_step;
    logic              do_finish;
    logic              last_plane;
    logic [2:0]        msb_row;

    logic [COLS-1:0]   plane;
    logic [PCW-1:0]    pc [ROWS];
    logic [PW-1:0]     partial;
    logic [PW-1:0]     term;
    logic [OUTW-1:0]   shifted;

    assign last_plane = (bit_idx == (inw_lat ? 3'd3 : 3'd7));
    assign msb_row    = ww_lat ? 3'd3 : 3'd7;

    // Weight array: no reset, each enabled row captures D on every edge
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (bus.WA[r]) begin
                weights[r] <= bus.D;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; start is only honoured outside COMPUTE
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    do_load    = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                do_step = 1'b1;
                if (last_plane) begin
                    do_finish  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Current input bit-plane: bit b of every latched lane
    always_comb begin
        plane = '0;
        for (int k = 0; k < COLS; k++) begin
            logic [7:0] lane;
            lane     = x_lat[8*k +: 8];
            plane[k] = lane[bit_idx];
        end
    end

    // Per-row popcount of plane AND stored row
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            pc[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                pc[r] = pc[r] + PCW'(plane[c] & weights[r][c]);
            end
        end
    end

    // Row-weighted partial sum; in signed mode the top active row is negative
    always_comb begin
        partial = '0;
        term    = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r <= int'(msb_row)) begin
                term = PW'(pc[r]) << r;
                if (cima_lat && (r == int'(msb_row))) begin
                    partial = partial - term;
                end else begin
                    partial = partial + term;
                end
            end
        end
    end

    // Plane-weighted accumulate; in signed mode the last plane is negative
    always_comb begin
        shifted  = {{(OUTW-PW){partial[PW-1]}}, partial} << bit_idx;
        acc_next = (cima_lat && last_plane) ? (acc - shifted) : (acc + shifted);
    end

    // Operand latch, accumulator, bit index and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_lat    <= '0;
            cima_lat <= 1'b0;
            inw_lat  <= 1'b0;
            ww_lat   <= 1'b0;
            bit_idx  <= '0;
            acc      <= '0;
            nout_r   <= '0;
            st_r     <= 1'b0;
        end else if (do_load) begin
            x_lat    <= bus.xin0;
            cima_lat <= bus.cima;
            inw_lat  <= bus.inwidth;
            ww_lat   <= bus.wwidth;
            bit_idx  <= '0;
            acc      <= '0;
            st_r     <= 1'b0;
        end else if (do_step) begin
            acc     <= acc_next;
            bit_idx <= bit_idx + 3'd1;
            if (do_finish) begin
                nout_r <= acc_next;
                st_r   <= 1'b1;
            end
        end
    end

    assign bus.nout = nout_r;
    assign bus.st   = st_r;

endmodule

// File: tb/tb_dcim_macro_top.sv
// tb_dcim_macro_top
// Self-checking bench for dcim_macro_top. Keeps its own copy of every
// weight row written and computes expected dot products lane by lane with
// plain integer arithmetic. Directed cases come first, then random weights,
// activations and modes.
module tb_dcim_macro_top;

    logic        clk = 1'b0;
    logic        rstn;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] w_model [8];
    logic [63:0] last_nout = '0;

    dcim_macro_top_if bus ();

    dcim_macro_top dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // One comparison: count it, flag and report on mismatch
    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expected);
        end
    endtask

    // Exact dot product from lane values, truncated to the 51-bit output
    function automatic logic [63:0] ref_dot(input logic [191:0] x, input logic c,
                                            input logic iw, input logic ww);
        longint sum;
        longint xv;
        longint wv;
        int     n;
        int     m;
        sum = 0;
        n   = iw ? 4 : 8;
        m   = ww ? 4 : 8;
        for (int k = 0; k < 24; k++) begin
            xv = 0;
            wv = 0;
            for (int i = 0; i < n; i++) begin
                if (x[8*k+i]) xv += longint'(1) << i;
            end
            if (c && xv >= (longint'(1) << (n-1))) xv -= longint'(1) << n;
            for (int r = 0; r < m; r++) begin
                if (w_model[r][k]) wv += longint'(1) << r;
            end
            if (c && wv >= (longint'(1) << (m-1))) wv -= longint'(1) << m;
            sum += xv * wv;
        end
        ref_dot = 64'(sum) & ((64'd1 << 51) - 64'd1);
    endfunction

    // Write the selected rows and mirror the write in the model
    task automatic apply_stimulus(input logic [7:0] wa, input logic [23:0] d);
        @(negedge clk);
        bus.WA = wa;
        bus.D  = d;
        @(negedge clk);
        bus.WA = '0;
        for (int r = 0; r < 8; r++) begin
            if (wa[r]) w_model[r] = d;
        end
    endtask

    // Start one computation, check timing, result and hold behaviour.
    // With disturb set, start and all operand pins are scrambled mid-compute.
    task automatic run_compute(input string tag, input logic [191:0] x, input logic c,
                               input logic iw, input logic ww, input bit disturb);
        logic [63:0] expected;
        int          lat;
        int          n;
        expected = ref_dot(x, c, iw, ww);
        n        = iw ? 4 : 8;
        lat      = 0;
        @(negedge clk);
        bus.xin0    = x;
        bus.cima    = c;
        bus.inwidth = iw;
        bus.wwidth  = ww;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_output({tag, "_st_clr"}, 64'(bus.st), 64'd0);
        check_output({tag, "_nout_hold_start"}, 64'(bus.nout), last_nout);
        for (int i = 1; i <= 40; i++) begin
            if (disturb && i == 3) begin
                bus.start   = 1'b1;
                bus.xin0    = {6{$urandom}};
                bus.cima    = ~c;
                bus.inwidth = ~iw;
                bus.wwidth  = ~ww;
            end
            if (disturb && i == 4) bus.start = 1'b0;
            @(negedge clk);
            if (bus.st === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        check_output({tag, "_latency"}, 64'(lat), 64'(n));
        check_output({tag, "_nout"}, 64'(bus.nout), expected);
        repeat (3) @(negedge clk);
        check_output({tag, "_st_hold"}, 64'(bus.st), 64'd1);
        check_output({tag, "_nout_hold"}, 64'(bus.nout), expected);
        last_nout = expected;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.cima    = 1'b0;
        bus.inwidth = 1'b0;
        bus.wwidth  = 1'b0;
        bus.WA      = '0;
        bus.D       = '0;
        bus.xin0    = '0;
        rstn        = 1'b1;

        // Reset values, then release with start low
        #2 rstn = 1'b0;
        #1;
        check_output("reset_nout", 64'(bus.nout), 64'd0);
        check_output("reset_st", 64'(bus.st), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_output("release_nout", 64'(bus.nout), 64'd0);
        check_output("release_st", 64'(bus.st), 64'd0);

        // Rows 0..7 loaded one at a time with 9+i
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(8'(1 << i), 24'(9 + i));
        end

        run_compute("t2_u8x8", {24{8'hAA}}, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("t2_const", 64'(bus.nout), 64'h17534);

        run_compute("t3_in4", {24{8'hAA}}, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("t3_const", 64'(bus.nout), 64'h15F4);

        run_compute("t4_w4", {24{8'hAA}}, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("t4_const", 64'(bus.nout), 64'h1694);

        // Restart and operand changes during COMPUTE are ignored
        run_compute("t6a_disturb", {24{8'hAA}}, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("t6a_const", 64'(bus.nout), 64'h17534);

        // Reset in the middle of a computation
        @(negedge clk);
        bus.xin0  = {24{8'hAA}};
        bus.cima  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_output("t6b_rst_nout", 64'(bus.nout), 64'd0);
        check_output("t6b_rst_st", 64'(bus.st), 64'd0);
        last_nout = '0;
        @(negedge clk);
        rstn = 1'b1;
        run_compute("t6b_after", {24{8'hAA}}, 1'b0, 1'b0, 1'b0, 1'b0);

        // Signed: all weights -1, all inputs +1
        apply_stimulus(8'hFF, 24'hFFFFFF);
        run_compute("t5_signed", {24{8'h01}}, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("t5_const", 64'(bus.nout), 64'h7FFFFFFFFFFE8);

        // Random weights (multi-hot writes), activations and modes
        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < 3; j++) begin
                apply_stimulus(8'($urandom_range(0, 255)), 24'($urandom));
            end
            run_compute("rnd", {6{$urandom}}, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcim_macro_top.md
Name: dcim_macro_top

Overview:
- Digital compute-in-memory macro: 8-row x 24-column SRAM-style bit-cell array holds 24 weights, bit-sliced (row r = weight bit r).
- On `start`, computes the dot product of 24 input activations (packed in `xin0`) with the 24 stored weights, bit-serially over input bit-planes, LSB first.
- Result is presented on `nout`; `st` flags completion.
- Sits as the top of the DCIM macro and is driven by a host controller.

Parameters:
- ROWS, 8, weight bit-rows (max weight width).
- COLS, 24, columns = number of weight/input lanes.
- OUTW, 51, output width.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  compute request, sampled on clk
- cima  in  1  arithmetic mode: 0 unsigned, 1 signed two's complement (inputs and weights)
- inwidth  in  1  input precision: 0 = 8-bit, 1 = 4-bit
- wwidth  in  1  weight precision: 0 = 8-bit, 1 = 4-bit
- WA  in  8  one-hot/multi-hot row write enables
- D  in  24  row write data; bit c -> column c
- xin0  in  192  activations; lane k = xin0[8k+7:8k]
- nout  out  51  dot-product result
- st  out  1  done flag

Behaviour:
- Reset (rstn low, async): nout=0, st=0, FSM=IDLE, accumulator and bit counter cleared. Weight array contents are not reset (undefined until written).
- Weight write:
  - Every rising edge, each row r with WA[r]=1 loads D.
  - Multiple set bits write all selected rows; WA=0 writes nothing.
  - Writes are allowed in any state. A write during COMPUTE takes effect from the next compute cycle.
- Weight of lane c: w_c = sum over active rows r of W[r][c]·2^r.
  - Active rows: 0..7 (wwidth=0) or 0..3 (wwidth=1; rows 4-7 ignored).
  - cima=1: the top active row carries weight −2^(M−1), where M is the active weight width.
- Input lane k:
  - inwidth=0: xin0[8k+7:8k], N=8.
  - inwidth=1: xin0[8k+3:8k], N=4.
  - cima=1: bit N−1 is negative.
- Result: sum over k of x_k·w_k, computed exactly. Zero-extended (cima=0) or sign-extended (cima=1) to 51 bits.
- FSM: IDLE -> COMPUTE -> DONE.
  - IDLE/DONE with start=1 at an edge (E0):
    - latch xin0, cima, inwidth, wwidth;
    - clear accumulator and bit index b;
    - st<=0; enter COMPUTE.
  - COMPUTE, each edge:
    - plane = {x_k[b]} across lanes;
    - per active row r: pc_r = popcount(plane AND W[r]) (0..24);
    - partial = sum ±pc_r·2^r;
    - acc += ±partial·2^b (negative sign only for the cima=1 MSB row/plane);
    - b++.
  - At edge E_N (last plane): nout<=final acc, st<=1, enter DONE.
- Latency: st rises exactly N edges after E0 (8 or 4 cycles).
- st stays high and nout holds until the next accepted start. nout is not cleared on start; it only updates at completion.
- start while in COMPUTE is ignored. Changes to xin0 or mode pins during COMPUTE have no effect.
- Reset mid-compute aborts: outputs return to reset values immediately.

Test Plan:
1. Reset -> nout=0, st=0. Release rstn with start=0 -> outputs unchanged.
2. Write rows 0..7 via WA=1<<i with D=9+i; xin0 all bytes 0xAA; cima=0, inwidth=0, wwidth=0; pulse start -> st=1 exactly 8 cycles after the start edge, nout=0x17534 (95540).
3. Same weights; inwidth=1 (lane value 0xA) -> st after 4 cycles, nout=0x15F4 (5620).
4. Same weights, inputs 0xAA; wwidth=1 -> nout=0x1694 (5780), rows 4-7 ignored.
5. cima=1, all rows 0xFFFFFF (w=−1), all input bytes 0x01 -> nout=0x7FFFFFFFFFFE8 (−24).
6. Mid-compute checks:
   - Assert start again during COMPUTE -> ignored, result and timing as in test 2.
   - Drop rstn mid-compute -> nout=0, st=0 immediately; the next start completes normally.
